// File: rtl/ieee488_source_ctrl.sv
// IEEE-488 source handshake controller: byte FIFO feeding a DAV/NRFD/NDAC talker FSM.
// Optional handshake timeout is built when IEEE488_SOURCE_TIMEOUT_EN is defined.
module ieee488_source_ctrl #(
    parameter int FIFO_DEPTH    = 4,
    parameter int SETTLE_TICKS  = 2,
    parameter int TIMEOUT_TICKS = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic [7:0] wr_data,
    input  logic       wr_eoi,
    input  logic       wr_atn,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic       ieee488_nrfd_i,
    input  logic       ieee488_ndac_i,
    output logic [7:0] ieee488_data_o,
    output logic       ieee488_dav_o,
    output logic       ieee488_eoi_o,
    output logic       ieee488_atn_o,
    output logic       busy,
    output logic       err,
    input  logic       err_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = $clog2(SETTLE_TICKS + 1);

    generate
        if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
            SETTLE_TICKS < 1 || TIMEOUT_TICKS < 1) begin : g_param_check
            $error("ieee488_source_ctrl: illegal parameter value");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_WAIT_RFD,
        S_DAV_LOW,
        S_WAIT_NDAC_LOW,
        S_ERROR
    } state_t;

    state_t          state_q, state_d;
    logic [9:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [SW-1:0]   settle_q, settle_d;
    logic [7:0]      data_q, data_d;
    logic            dav_q, dav_d;
    logic            eoi_q, eoi_d;
    logic            atn_q, atn_d;
    logic            eoi_bit_q, eoi_bit_d;
    logic            err_q, err_d;

    logic            fifo_empty, fifo_full, push, pop, flush, enter_err;
    logic [9:0]      head;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign wr_ready   = !fifo_full;
    assign push       = wr_valid && !fifo_full && !err_q;
    assign flush      = (state_q == S_ERROR);
    assign head       = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {wr_atn, wr_eoi, wr_data};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef IEEE488_SOURCE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          hs_state;

    assign hs_state = (state_q == S_WAIT_RFD) || (state_q == S_DAV_LOW) ||
                      (state_q == S_WAIT_NDAC_LOW);

    // Reloads on every state change, so each handshake phase gets its own budget.
    always_comb begin
        tmo_d = tmo_q;
        if (!hs_state || state_d != state_q) begin
            tmo_d = TW'(TIMEOUT_TICKS - 1);
        end else if (ce) begin
            tmo_d = tmo_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) tmo_q <= TW'(TIMEOUT_TICKS - 1);
        else       tmo_q <= tmo_d;
    end
`endif

    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        data_d    = data_q;
        dav_d     = dav_q;
        eoi_d     = eoi_q;
        atn_d     = atn_q;
        eoi_bit_d = eoi_bit_q;
        pop       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (ce) begin
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        data_d    = ~head[7:0];
                        atn_d     = ~head[9];
                        eoi_bit_d = head[8];
                        settle_d  = SW'(SETTLE_TICKS - 1);
                        state_d   = S_SETTLE;
                    end else begin
                        atn_d = 1'b1;
                    end
                end
            end
            // The pop tick already counts as the first tick of data stability.
            S_SETTLE: begin
                if (ce) begin
                    if (settle_q <= SW'(1)) state_d  = S_WAIT_RFD;
                    else                    settle_d = settle_q - 1'b1;
                end
            end
            S_WAIT_RFD: begin
                if (ce && ieee488_nrfd_i) begin
                    if (ieee488_ndac_i) begin
                        state_d = S_ERROR;
                    end else begin
                        dav_d   = 1'b0;
                        eoi_d   = ~eoi_bit_q;
                        state_d = S_DAV_LOW;
                    end
                end
            end
            S_DAV_LOW: begin
                if (ce && ieee488_ndac_i) begin
                    dav_d   = 1'b1;
                    eoi_d   = 1'b1;
                    state_d = S_WAIT_NDAC_LOW;
                end
            end
            S_WAIT_NDAC_LOW: begin
                if (ce && !ieee488_ndac_i) begin
                    data_d  = 8'hFF;
                    state_d = S_IDLE;
                end
            end
            S_ERROR: begin
                if (ce) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

`ifdef IEEE488_SOURCE_TIMEOUT_EN
        if (ce && hs_state && tmo_q == '0 && state_d == state_q) begin
            state_d = S_ERROR;
        end
`endif

        enter_err = (state_d == S_ERROR) && (state_q != S_ERROR);
        if (enter_err) begin
            data_d = 8'hFF;
            dav_d  = 1'b1;
            eoi_d  = 1'b1;
            atn_d  = 1'b1;
        end

        err_d = err_q;
        if (err_clr)   err_d = 1'b0;
        if (enter_err) err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            settle_q  <= '0;
            data_q    <= 8'hFF;
            dav_q     <= 1'b1;
            eoi_q     <= 1'b1;
            atn_q     <= 1'b1;
            eoi_bit_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            data_q    <= data_d;
            dav_q     <= dav_d;
            eoi_q     <= eoi_d;
            atn_q     <= atn_d;
            eoi_bit_q <= eoi_bit_d;
            err_q     <= err_d;
        end
    end

    assign ieee488_data_o = data_q;
    assign ieee488_dav_o  = dav_q;
    assign ieee488_eoi_o  = eoi_q;
    assign ieee488_atn_o  = atn_q;
    assign err            = err_q;
    assign busy           = !fifo_empty || (state_q != S_IDLE);

endmodule

// File: tb/tb_ieee488_source_ctrl.sv
// Directed bench for ieee488_source_ctrl: vector table of single-byte handshakes
// plus hand-written sequences for ATN, error, FIFO full, reset and timeout cases.
module tb_ieee488_source_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       ce;
    logic [7:0] wr_data;
    logic       wr_eoi, wr_atn, wr_valid, wr_ready;
    logic       nrfd, ndac;
    logic [7:0] data_o;
    logic       dav_o, eoi_o, atn_o, busy, err, err_clr;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ieee488_source_ctrl #(
        .FIFO_DEPTH   (4),
        .SETTLE_TICKS (2),
        .TIMEOUT_TICKS(16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ce            (ce),
        .wr_data       (wr_data),
        .wr_eoi        (wr_eoi),
        .wr_atn        (wr_atn),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .ieee488_nrfd_i(nrfd),
        .ieee488_ndac_i(ndac),
        .ieee488_data_o(data_o),
        .ieee488_dav_o (dav_o),
        .ieee488_eoi_o (eoi_o),
        .ieee488_atn_o (atn_o),
        .busy          (busy),
        .err           (err),
        .err_clr       (err_clr)
    );

    typedef struct {
        logic [7:0] data;
        logic       eoi;
        logic       atn;
        int         rfd_delay;
        int         exp_lat;
        logic [7:0] exp_data;
        logic       exp_eoi;
        logic       exp_atn;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic e, input logic a);
        wr_data  = d;
        wr_eoi   = e;
        wr_atn   = a;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic wait_dav(input logic lvl, input int max, input string name, output int n);
        n = 0;
        while (dav_o !== lvl && n < max) begin
            tick();
            n++;
        end
        if (dav_o !== lvl) chk(name, {31'd0, dav_o}, {31'd0, lvl});
    endtask

    // Listener that accepts immediately; reports bus data/ATN at DAV and ATN-released samples while waiting.
    task automatic accept(output logic [7:0] d, output logic a, output int rel, output int dav_cyc);
        int n;
        n   = 0;
        rel = 0;
        while (dav_o !== 1'b0 && n < 50) begin
            if (atn_o === 1'b1) rel++;
            tick();
            n++;
        end
        if (atn_o === 1'b1) rel++;
        if (dav_o !== 1'b0) chk("accept_dav_fall", {31'd0, dav_o}, 32'd0);
        dav_cyc = cyc;
        d       = data_o;
        a       = atn_o;
        ndac    = 1'b1;
        wait_dav(1'b1, 20, "accept_dav_rise", n);
        ndac    = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        logic       a;
        int         rel, dc, dc_prev, n, lat, lows;

        vecs[0] = '{8'h41, 1'b0, 1'b0, 0, 3, 8'hBE, 1'b1, 1'b1};
        vecs[1] = '{8'h00, 1'b1, 1'b0, 0, 3, 8'hFF, 1'b0, 1'b1};
        vecs[2] = '{8'hFF, 1'b0, 1'b1, 0, 3, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{8'hA5, 1'b1, 1'b1, 5, 6, 8'h5A, 1'b0, 1'b0};
        vecs[4] = '{8'h3C, 1'b0, 1'b0, 2, 3, 8'hC3, 1'b1, 1'b1};

        reset = 1'b1; ce = 1'b1; wr_data = 8'h00; wr_eoi = 1'b0; wr_atn = 1'b0;
        wr_valid = 1'b0; nrfd = 1'b1; ndac = 1'b0; err_clr = 1'b0;

        #3;
        chk("rst_data", {24'd0, data_o}, 32'hFF);
        chk("rst_lines", {29'd0, dav_o, eoi_o, atn_o}, 32'h7);
        chk("rst_busy_err", {30'd0, busy, err}, 32'h0);
        tick(); tick();
        chk("rst_wr_ready_held", {31'd0, wr_ready}, 32'd1);
        reset = 1'b0;
        tick();

        // Vector table: one byte per row with optional NRFD hold-off.
        for (int i = 0; i < 5; i++) begin
            ndac = 1'b0;
            nrfd = (vecs[i].rfd_delay == 0);
            push(vecs[i].data, vecs[i].eoi, vecs[i].atn);
            lat = 0;
            for (int k = 0; k < vecs[i].rfd_delay; k++) begin
                tick();
                lat++;
            end
            nrfd = 1'b1;
            wait_dav(1'b0, 20, "vec_dav_timeout", n);
            lat += n;
            chk($sformatf("vec%0d_dav_latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("vec%0d_data", i), {24'd0, data_o}, {24'd0, vecs[i].exp_data});
            chk($sformatf("vec%0d_eoi", i), {31'd0, eoi_o}, {31'd0, vecs[i].exp_eoi});
            chk($sformatf("vec%0d_atn", i), {31'd0, atn_o}, {31'd0, vecs[i].exp_atn});
            chk($sformatf("vec%0d_busy", i), {31'd0, busy}, 32'd1);
            repeat (3) tick();
            chk($sformatf("vec%0d_dav_hold", i), {31'd0, dav_o}, 32'd0);
            ndac = 1'b1;
            tick();
            chk($sformatf("vec%0d_dav_rise", i), {30'd0, dav_o, eoi_o}, 32'h3);
            ndac = 1'b0;
            tick();
            chk($sformatf("vec%0d_data_idle", i), {24'd0, data_o}, 32'hFF);
            chk($sformatf("vec%0d_busy_done", i), {31'd0, busy}, 32'd0);
            tick();
            chk($sformatf("vec%0d_atn_rel", i), {31'd0, atn_o}, 32'd1);
        end

        // Clock enable low: push lands, FSM holds.
        ce = 1'b0;
        push(8'h12, 1'b0, 1'b0);
        chk("ce_busy", {31'd0, busy}, 32'd1);
        repeat (4) tick();
        chk("ce_no_pop", {24'd0, data_o}, 32'hFF);
        ce = 1'b1;
        accept(d, a, rel, dc);
        chk("ce_data", {24'd0, d}, 32'hED);
        repeat (2) tick();

        // Two command bytes then a data byte: ATN held across commands, back-to-back DAV gap.
        push(8'h28, 1'b0, 1'b1);
        push(8'h3F, 1'b0, 1'b1);
        push(8'h55, 1'b0, 1'b0);
        accept(d, a, rel, dc);
        chk("atn_b1_data", {24'd0, d}, 32'hD7);
        chk("atn_b1_atn", {31'd0, a}, 32'd0);
        dc_prev = dc;
        accept(d, a, rel, dc);
        chk("atn_b2_data", {24'd0, d}, 32'hC0);
        chk("atn_b2_held", {31'd0, a}, 32'd0);
        chk("atn_b2_no_release", rel, 0);
        chk("atn_b2_gap", dc - dc_prev, 5);
        dc_prev = dc;
        accept(d, a, rel, dc);
        chk("atn_b3_data", {24'd0, d}, 32'hAA);
        chk("atn_b3_released", {31'd0, a}, 32'd1);
        chk("atn_b3_release_time", rel, 3);
        chk("atn_b3_gap", dc - dc_prev, 5);
        repeat (2) tick();
        chk("atn_busy_done", {31'd0, busy}, 32'd0);

        // No listener: error, flush, blocked pushes, clear.
        nrfd = 1'b1; ndac = 1'b1;
        push(8'h10, 1'b1, 1'b1);
        push(8'h11, 1'b0, 1'b0);
        n = 0;
        while (err !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("err_set", {31'd0, err}, 32'd1);
        chk("err_data_rel", {24'd0, data_o}, 32'hFF);
        chk("err_lines_rel", {29'd0, dav_o, eoi_o, atn_o}, 32'h7);
        tick();
        chk("err_flushed", {31'd0, busy}, 32'd0);
        push(8'h22, 1'b0, 1'b0);
        tick();
        chk("err_push_ignored", {30'd0, busy, err}, 32'h1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("err_clr", {31'd0, err}, 32'd0);
        ndac = 1'b0;
        push(8'h77, 1'b0, 1'b0);
        accept(d, a, rel, dc);
        chk("err_after_clr_data", {24'd0, d}, 32'h88);
        repeat (2) tick();
        chk("err_after_clr_idle", {31'd0, busy}, 32'd0);

        // err_clr on the very edge that enters ERROR: set wins.
        ndac = 1'b1;
        push(8'h33, 1'b0, 1'b0);
        tick();
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("err_set_priority", {31'd0, err}, 32'd1);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("err_clr_again", {31'd0, err}, 32'd0);
        ndac = 1'b0;

        // FIFO full: one byte in the handshake plus four queued; the sixth push is dropped.
        nrfd = 1'b0;
        wr_valid = 1'b1; wr_eoi = 1'b0; wr_atn = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wr_data = 8'hC0 + 8'(i);
            tick();
        end
        wr_valid = 1'b0;
        chk("full_wr_ready", {31'd0, wr_ready}, 32'd0);
        nrfd = 1'b1;
        for (int i = 0; i < 5; i++) begin
            accept(d, a, rel, dc);
            chk($sformatf("full_order%0d", i), {24'd0, d}, {24'd0, ~(8'hC0 + 8'(i))});
        end
        lows = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (dav_o === 1'b0) lows++;
        end
        chk("full_extra_dropped", lows, 0);
        chk("full_busy_done", {31'd0, busy}, 32'd0);

        // Reset mid-handshake releases the bus immediately.
        push(8'h5A, 1'b1, 1'b1);
        wait_dav(1'b0, 20, "rst_mid_dav", n);
        chk("rst_mid_pre", {29'd0, dav_o, eoi_o, atn_o}, 32'h0);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_lines", {29'd0, dav_o, eoi_o, atn_o}, 32'h7);
        chk("rst_mid_data", {24'd0, data_o}, 32'hFF);
        chk("rst_mid_busy", {30'd0, busy, wr_ready}, 32'h1);
        tick();
        reset = 1'b0;
        tick();
        chk("rst_mid_after", {31'd0, busy}, 32'd0);

        // Stalled listener after DAV.
        push(8'h66, 1'b0, 1'b0);
        wait_dav(1'b0, 20, "tmo_dav", n);
`ifdef IEEE488_SOURCE_TIMEOUT_EN
        repeat (15) tick();
        chk("tmo_not_yet", {31'd0, err}, 32'd0);
        tick();
        chk("tmo_err", {31'd0, err}, 32'd1);
        chk("tmo_lines_rel", {29'd0, dav_o, eoi_o, atn_o}, 32'h7);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("tmo_clr", {31'd0, err}, 32'd0);
`else
        repeat (40) tick();
        chk("no_tmo_err", {31'd0, err}, 32'd0);
        chk("no_tmo_dav_held", {31'd0, dav_o}, 32'd0);
        ndac = 1'b1;
        wait_dav(1'b1, 20, "no_tmo_rise", n);
        ndac = 1'b0;
        repeat (2) tick();
        chk("no_tmo_done", {31'd0, busy}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
